// File: rtl/lfsr_prbs_gen_if.sv
// lfsr_prbs_gen_if -- host/consumer bundle for the PRBS generator.
//   enable      host -> gen   request to run the generator
//   seed_load   host -> gen   load seed_data into the LFSR this cycle
//   seed_data   host -> gen   seed value (WIDTH bits)
//   out_ready   cons -> gen   consumer accepts out_data
//   out_valid   gen  -> cons  out_data holds a word
//   out_data    gen  -> cons  current LFSR state
//   out_bit     gen  -> cons  serial PRBS bit (out_data MSB)
//   seed_err    gen  -> host  one-cycle pulse: all-zero seed/state replaced by SEED
//   period_wrap gen  -> host  one-cycle pulse: state returned to reference seed
//   period_len  gen  -> host  step count of the last completed period
// The generator is the master (data source); host/consumer is the slave.
interface lfsr_prbs_gen_if #(
   parameter int unsigned WIDTH = 16
);
   logic             enable;
   logic             seed_load;
   logic [WIDTH-1:0] seed_data;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_bit;
   logic             seed_err;
   logic             period_wrap;
   logic [31:0]      period_len;

   modport master (
      input  enable, seed_load, seed_data, out_ready,
      output out_valid, out_data, out_bit, seed_err, period_wrap, period_len
   );

   modport slave (
      output enable, seed_load, seed_data, out_ready,
      input  out_valid, out_data, out_bit, seed_err, period_wrap, period_len
   );
endinterface

// File: rtl/lfsr_prbs_gen.sv
// lfsr_prbs_gen -- Fibonacci/Galois LFSR pseudo-random sequence generator
// with valid/ready output handshake, host seeding and period measurement.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    lfsr_prbs_gen_if master modport (see interface header)
// Parameters: WIDTH (3..32), TAPS (tap mask, MSB set), MODE (0 Fib, 1 Galois),
// SEED (nonzero reset/substitute seed).
module lfsr_prbs_gen #(
   parameter int unsigned      WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
   parameter int unsigned      MODE  = 0,
   parameter logic [WIDTH-1:0] SEED  = 16'h0010
) (
   input  logic             clk,
   input  logic             reset,
   lfsr_prbs_gen_if.master  bus
);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t             fsm;
   logic [WIDTH-1:0] lfsr;
   logic [WIDTH-1:0] ref_seed;
   logic [WIDTH-1:0] step_next;
   logic [31:0]      step_cnt;
   logic [31:0]      cnt_inc;
   logic [31:0]      plen_q;
   logic             valid_q;
   logic             err_q;
   logic             wrap_q;

   // One LFSR step from the current state.
   always_comb begin
      step_next = '0;
      if (MODE == 0) begin
         step_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
      end else begin
         step_next[0] = lfsr[WIDTH-1];
         for (int unsigned i = 1; i < WIDTH; i++) begin
            step_next[i] = lfsr[i-1] ^ (lfsr[WIDTH-1] & TAPS[i-1]);
         end
      end
   end

   // Saturating increment of the step counter.
   always_comb begin
      cnt_inc = (step_cnt == '1) ? step_cnt : step_cnt + 32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr     <= SEED;
         ref_seed <= SEED;
         fsm      <= IDLE;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         wrap_q   <= 1'b0;
         plen_q   <= '0;
         step_cnt <= '0;
      end else begin
         err_q  <= 1'b0;
         wrap_q <= 1'b0;
         if (bus.seed_load) begin
            // Seeding wins over any concurrent handshake; that step is dropped.
            if (bus.seed_data == '0) begin
               lfsr     <= SEED;
               ref_seed <= SEED;
               err_q    <= 1'b1;
            end else begin
               lfsr     <= bus.seed_data;
               ref_seed <= bus.seed_data;
            end
            fsm      <= IDLE;
            valid_q  <= 1'b0;
            step_cnt <= '0;
         end else if (lfsr == '0) begin
            // Lock-up recovery; unreachable from a legal seed but kept as a guard.
            lfsr  <= SEED;
            err_q <= 1'b1;
         end else begin
            case (fsm)
               IDLE: begin
                  if (bus.enable) begin
                     fsm     <= RUN;
                     valid_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.out_ready) begin
                     lfsr <= step_next;
                     if (step_next == ref_seed) begin
                        plen_q   <= cnt_inc;
                        step_cnt <= '0;
                        wrap_q   <= 1'b1;
                     end else begin
                        step_cnt <= cnt_inc;
                     end
                     if (!bus.enable) begin
                        fsm     <= IDLE;
                        valid_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  fsm     <= IDLE;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.out_valid   = valid_q;
   assign bus.out_data    = lfsr;
   assign bus.out_bit     = lfsr[WIDTH-1];
   assign bus.seed_err    = err_q;
   assign bus.period_wrap = wrap_q;
   assign bus.period_len  = plen_q;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// tb_lfsr_prbs_gen -- drives a Fibonacci and a Galois instance with identical
// stimulus and checks both against a cycle-level behavioural model.
module tb_lfsr_prbs_gen;

   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [15:0] SEED = 16'h0010;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   lfsr_prbs_gen_if #(.WIDTH(16)) fi ();
   lfsr_prbs_gen_if #(.WIDTH(16)) gi ();

   lfsr_prbs_gen #(.WIDTH(16), .TAPS(TAPS), .MODE(0), .SEED(SEED)) u_fib (
      .clk(clk), .reset(reset), .bus(fi.master)
   );
   lfsr_prbs_gen #(.WIDTH(16), .TAPS(TAPS), .MODE(1), .SEED(SEED)) u_gal (
      .clk(clk), .reset(reset), .bus(gi.master)
   );

   // Behavioural model, index 0 = Fibonacci, 1 = Galois.
   logic [15:0] m_state [2];
   logic [15:0] m_ref   [2];
   logic [31:0] m_cnt   [2];
   logic [31:0] m_plen  [2];
   bit          m_run   [2];
   bit          m_err   [2];
   bit          m_wrap  [2];

   function automatic logic [15:0] nxt(input logic [15:0] s, input int mode);
      int unsigned v, msb;
      v = s;
      if (mode == 0) begin
         return 16'(((v << 1) | ($countones(v & TAPS) % 2)) & 32'hFFFF);
      end
      msb = v >> 15;
      return 16'((((v << 1) ^ (msb != 0 ? (32'(TAPS) << 1) : 0)) | msb) & 32'hFFFF);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = SEED; m_ref[k] = SEED; m_cnt[k] = 0; m_plen[k] = 0;
         m_run[k] = 0; m_err[k] = 0; m_wrap[k] = 0;
      end
   endtask

   // Drive one cycle of stimulus into both DUTs, advance the model, sample at +1.
   task automatic cycle(input bit en, input bit ld, input logic [15:0] d, input bit rdy);
      fi.enable = en; fi.seed_load = ld; fi.seed_data = d; fi.out_ready = rdy;
      gi.enable = en; gi.seed_load = ld; gi.seed_data = d; gi.out_ready = rdy;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_err[k] = 0; m_wrap[k] = 0;
         if (ld) begin
            if (d == 0) begin
               m_state[k] = SEED; m_ref[k] = SEED; m_err[k] = 1;
            end else begin
               m_state[k] = d; m_ref[k] = d;
            end
            m_run[k] = 0; m_cnt[k] = 0;
         end else if (m_run[k] && rdy) begin
            m_state[k] = nxt(m_state[k], k);
            if (m_state[k] == m_ref[k]) begin
               m_plen[k] = (m_cnt[k] == 32'hFFFFFFFF) ? m_cnt[k] : m_cnt[k] + 1;
               m_cnt[k] = 0; m_wrap[k] = 1;
            end else if (m_cnt[k] != 32'hFFFFFFFF) begin
               m_cnt[k] = m_cnt[k] + 1;
            end
            if (!en) m_run[k] = 0;
         end else if (!m_run[k] && en) begin
            m_run[k] = 1;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fi.enable = 0; fi.seed_load = 0; fi.seed_data = '0; fi.out_ready = 0;
      gi.enable = 0; gi.seed_load = 0; gi.seed_data = '0; gi.out_ready = 0;
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (fi.out_data !== SEED) begin bad++; $display("FAIL reset_data got=%h exp=%h", fi.out_data, SEED); end
      total++; if (fi.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fi.out_valid); end
      total++; if (fi.seed_err !== 1'b0 || fi.period_wrap !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", fi.seed_err, fi.period_wrap); end
      total++; if (fi.period_len !== 32'd0) begin bad++; $display("FAIL reset_plen got=%0d exp=0", fi.period_len); end
      total++; if (gi.out_data !== SEED) begin bad++; $display("FAIL reset_gdata got=%h exp=%h", gi.out_data, SEED); end
      // Asynchronous assertion: take effect without a clock edge.
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      reset = 1'b1;
      #2;
      total++; if (fi.out_data !== SEED || fi.out_valid !== 1'b0) begin bad++; $display("FAIL reset_async got=%h/%b exp=%h/0", fi.out_data, fi.out_valid, SEED); end
      do_reset();
   endtask

   task automatic test_sequence();
      logic [15:0] exp_seq [8];
      exp_seq = '{16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0801};
      do_reset();
      cycle(1, 0, '0, 1);
      for (int i = 0; i < 8; i++) begin
         total++; if (fi.out_data !== exp_seq[i] || fi.out_valid !== 1'b1) begin bad++; $display("FAIL seq[%0d] got=%h/%b exp=%h/1", i, fi.out_data, fi.out_valid, exp_seq[i]); end
         total++; if (fi.out_bit !== exp_seq[i][15]) begin bad++; $display("FAIL seq_bit[%0d] got=%b exp=%b", i, fi.out_bit, exp_seq[i][15]); end
         total++; if (gi.out_data !== m_state[1]) begin bad++; $display("FAIL gseq[%0d] got=%h exp=%h", i, gi.out_data, m_state[1]); end
         if (i < 7) cycle(1, 0, '0, 1);
      end
   endtask

   task automatic test_stall();
      logic [15:0] held;
      held = fi.out_data;
      for (int i = 0; i < 5; i++) begin
         cycle(i % 2 == 0 ? 1'b0 : 1'b1, 0, '0, 0);
         total++; if (fi.out_data !== held || fi.out_valid !== 1'b1) begin bad++; $display("FAIL stall[%0d] got=%h/%b exp=%h/1", i, fi.out_data, fi.out_valid, held); end
      end
      cycle(0, 0, '0, 1);
      total++; if (fi.out_data !== nxt(held, 0) || fi.out_valid !== 1'b0) begin bad++; $display("FAIL stall_last got=%h/%b exp=%h/0", fi.out_data, fi.out_valid, nxt(held, 0)); end
      cycle(0, 0, '0, 1);
      total++; if (fi.out_data !== nxt(held, 0) || fi.out_valid !== 1'b0) begin bad++; $display("FAIL stall_idle got=%h/%b exp=%h/0", fi.out_data, fi.out_valid, nxt(held, 0)); end
   endtask

   task automatic test_seed_zero();
      cycle(0, 1, '0, 0);
      total++; if (fi.out_data !== 16'h0010 || fi.seed_err !== 1'b1) begin bad++; $display("FAIL seedzero got=%h/%b exp=0010/1", fi.out_data, fi.seed_err); end
      total++; if (gi.seed_err !== 1'b1) begin bad++; $display("FAIL seedzero_g got=%b exp=1", gi.seed_err); end
      cycle(0, 0, '0, 0);
      total++; if (fi.seed_err !== 1'b0 || fi.out_data !== 16'h0010) begin bad++; $display("FAIL seedzero_end got=%h/%b exp=0010/0", fi.out_data, fi.seed_err); end
   endtask

   task automatic test_collision();
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      cycle(1, 1, 16'hACE1, 1);
      total++; if (fi.out_data !== 16'hACE1 || fi.out_valid !== 1'b0) begin bad++; $display("FAIL collide got=%h/%b exp=ace1/0", fi.out_data, fi.out_valid); end
      cycle(0, 0, '0, 1);
      total++; if (fi.out_data !== 16'hACE1 || gi.out_data !== 16'hACE1) begin bad++; $display("FAIL collide_hold got=%h/%h exp=ace1", fi.out_data, gi.out_data); end
   endtask

   task automatic test_galois();
      cycle(0, 1, 16'h8000, 0);
      cycle(1, 0, '0, 0);
      cycle(1, 0, '0, 1);
      total++; if (gi.out_data !== 16'h6801) begin bad++; $display("FAIL galois got=%h exp=6801", gi.out_data); end
      total++; if (fi.out_data !== 16'h0001) begin bad++; $display("FAIL fib_8000 got=%h exp=0001", fi.out_data); end
   endtask

   task automatic test_reset_abort();
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      do_reset();
      cycle(1, 0, '0, 1);
      cycle(1, 0, '0, 1);
      total++; if (fi.out_data !== 16'h0020 || fi.period_len !== 32'd0) begin bad++; $display("FAIL abort got=%h/%0d exp=0020/0", fi.out_data, fi.period_len); end
   endtask

   task automatic test_random();
      bit en, ld, rdy;
      logic [15:0] d;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         en  = ($urandom % 4) != 0;
         rdy = ($urandom % 2) != 0;
         ld  = ($urandom % 25) == 0;
         d   = (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom);
         cycle(en, ld, d, rdy);
         total++; if (fi.out_data !== m_state[0] || fi.out_valid !== m_run[0]) begin bad++; $display("FAIL rnd_f[%0d] got=%h/%b exp=%h/%b", i, fi.out_data, fi.out_valid, m_state[0], m_run[0]); end
         total++; if (gi.out_data !== m_state[1] || gi.out_valid !== m_run[1]) begin bad++; $display("FAIL rnd_g[%0d] got=%h/%b exp=%h/%b", i, gi.out_data, gi.out_valid, m_state[1], m_run[1]); end
         total++; if (fi.seed_err !== m_err[0] || gi.seed_err !== m_err[1] || fi.period_wrap !== m_wrap[0] || gi.period_wrap !== m_wrap[1]) begin bad++; $display("FAIL rnd_pulse[%0d] got=%b%b%b%b exp=%b%b%b%b", i, fi.seed_err, gi.seed_err, fi.period_wrap, gi.period_wrap, m_err[0], m_err[1], m_wrap[0], m_wrap[1]); end
      end
   endtask

   task automatic test_period();
      int hs, wraps, wrap_at, extra;
      bit zero_seen;
      hs = 0; wraps = 0; wrap_at = -1; zero_seen = 0; extra = 0;
      do_reset();
      cycle(1, 0, '0, 1);
      for (int i = 0; i < 66000 && extra < 10; i++) begin
         cycle(1, 0, '0, 1);
         hs++;
         if (fi.out_data === 16'h0000) zero_seen = 1;
         if (fi.period_wrap === 1'b1) begin
            wraps++;
            if (wrap_at < 0) wrap_at = hs;
         end
         if (wrap_at >= 0) extra++;
         if (gi.out_data !== m_state[1] || gi.period_wrap !== m_wrap[1]) begin
            total++; bad++;
            $display("FAIL period_g[%0d] got=%h/%b exp=%h/%b", i, gi.out_data, gi.period_wrap, m_state[1], m_wrap[1]);
         end
      end
      total++; if (wrap_at != 65535) begin bad++; $display("FAIL period_at got=%0d exp=65535", wrap_at); end
      total++; if (wraps != 1) begin bad++; $display("FAIL period_count got=%0d exp=1", wraps); end
      total++; if (fi.period_len !== 32'd65535) begin bad++; $display("FAIL period_len got=%0d exp=65535", fi.period_len); end
      total++; if (zero_seen) begin bad++; $display("FAIL period_zero got=1 exp=0"); end
      total++; if (gi.period_len !== m_plen[1]) begin bad++; $display("FAIL period_glen got=%0d exp=%0d", gi.period_len, m_plen[1]); end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_stall();
      test_seed_zero();
      test_collision();
      test_galois();
      test_reset_abort();
      test_random();
      test_period();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_gen.md
LFSR_PRBS_GEN -- requirements
Module: lfsr_prbs_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR state width, legal range 3..32.
REQ-002 Parameter TAPS, default 16'hB400: tap mask, WIDTH bits; bit i set means state bit i is tapped; bit WIDTH-1 SHALL be set.
REQ-003 Parameter MODE, default 0: 0 = Fibonacci, 1 = Galois.
REQ-004 Parameter SEED, default 16'h0010: reset and substitute seed, WIDTH bits, nonzero.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  request to run the generator.
REQ-008 seed_load  in  1  load seed_data into the state this cycle.
REQ-009 seed_data  in  WIDTH  seed value from host.
REQ-010 out_valid  out  1  out_data holds a word for the consumer.
REQ-011 out_ready  in  1  consumer accepts out_data.
REQ-012 out_data  out  WIDTH  current LFSR state.
REQ-013 out_bit  out  1  serial PRBS bit, equal to out_data[WIDTH-1].
REQ-014 seed_err  out  1  one-cycle pulse: an all-zero seed was substituted.
REQ-015 period_wrap  out  1  one-cycle pulse: state returned to the last loaded seed.
REQ-016 period_len  out  32  step count of the last completed period.

Function
REQ-017 Fibonacci step: next = {state[WIDTH-2:0], fb}, where fb = XOR of state[i] for every i with TAPS[i]=1.
REQ-018 Galois step, with m = state[WIDTH-1]: next[0] = m, and next[i] = state[i-1] XOR (m AND TAPS[i-1]) for i = 1..WIDTH-1.
REQ-019 FSM states: IDLE and RUN; out_valid SHALL be 1 exactly when the FSM is in RUN.
REQ-020 IDLE -> RUN on the first edge where enable=1 and seed_load=0; the state register SHALL NOT change in IDLE except on seed_load.
REQ-021 A handshake is a cycle with out_valid=1 and out_ready=1 in RUN; each handshake SHALL advance the state exactly one step at that edge, so the next word is visible the following cycle.
REQ-022 RUN with no handshake: out_data and out_valid SHALL hold stable, whatever the value of enable.
REQ-023 RUN -> IDLE only on a handshake edge with enable=0; the state still advances on that edge.
REQ-024 seed_load=1 takes priority over the handshake in any state. Actions at that edge:
  - state <= seed_data; FSM <= IDLE; step counter <= 0;
  - seed_data is latched as the reference seed;
  - out_valid=0 the next cycle; the step is dropped even if a handshake occurred in the same cycle.
REQ-025 seed_data = 0 with seed_load: SEED is loaded and latched as the reference instead, and seed_err pulses the next cycle.
REQ-026 The state SHALL never become all-zero; if an all-zero state is detected, it is reloaded with SEED on the next edge and seed_err pulses.
REQ-027 Step counter: 32 bits, increments on each handshake. When the advanced state equals the reference seed:
  - period_len <= counter+1;
  - counter <= 0;
  - period_wrap pulses the next cycle.
REQ-028 The step counter saturates at 32'hFFFFFFFF and never wraps.
REQ-029 All outputs are registered except out_bit, which is a direct copy of out_data[WIDTH-1].

Reset
REQ-030 When reset is asserted, asynchronously:
  - state = SEED; reference seed = SEED; FSM = IDLE;
  - out_valid = 0; seed_err = 0; period_wrap = 0;
  - period_len = 0; step counter = 0.
REQ-031 Reset asserted mid-operation SHALL abort the current period; after reset release, the first handshake yields the SEED successor.

Verification
REQ-032 Defaults, reset, enable=1, out_ready=1 -> out_data sequence 0x0010, 0x0020, 0x0040, 0x0080, 0x0100, 0x0200, 0x0400, 0x0801.
REQ-033 Defaults, run with out_ready=1 continuously -> period_wrap pulses once after 65535 handshakes, period_len = 65535, and no all-zero state ever appears.
REQ-034 MODE=1, seed_load with seed_data=0x8000, then one handshake -> out_data = 0x6801.
REQ-035 seed_load with seed_data=0 -> state = 0x0010 and seed_err pulses for exactly one cycle.
REQ-036 out_ready=0 for 5 cycles in RUN, with enable toggling -> out_data stays stable and out_valid stays 1; after that, one handshake with enable=0 -> one step, then IDLE.
REQ-037 seed_load in the same cycle as a handshake -> the seed wins, out_valid=0 the next cycle, and no step is taken.
